wifi_deinterleaver_sched: RTL and testbench
===========================================

WIFI_DEINTERLEAVER_SCHED -- requirements
Module: wifi_deinterleaver_sched

Interface
REQ-001 Parameter NSYM_W, default 12, width of the symbol counter.
REQ-002 Parameter WDOG_MAX, default 1023, maximum number of cycles to wait for the deinterleaver readout.
REQ-003 Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
REQ-004 Ports:
- start  input  1  one-cycle pulse that begins a frame.
- rate  input  4  802.11a RATE code, sampled on start.
- n_sym  input  NSYM_W  number of OFDM symbols, sampled on start.
REQ-005 Ports:
- bit_in  input  1  coded bit from the demapper.
- bit_valid  input  1  qualifies bit_in.
- bit_ready  output  1  scheduler accepts bits.
REQ-006 Ports:
- deint_finished  input  1  deinterleaver idle flag.
- deint_enable  output  1  deinterleaver enable.
- deint_data  output  1  bit to the deinterleaver.
- deint_valid  output  1  qualifies deint_data.
REQ-007 Ports:
- ncbps  output  9  coded bits per symbol of the current frame.
- sym_count  output  NSYM_W  symbols completed.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- err  output  2  sticky error flags: bit0 overflow/rate, bit1 watchdog.

Function
REQ-010 The rate map SHALL be:
- 1101, 1111 -> 48
- 0101, 0111 -> 96
- 1001, 1011 -> 192
- 0001, 0011 -> 288
- any other code SHALL set err[0], pulse done, and return to IDLE without feeding any bits.
REQ-011 The FSM SHALL have the states IDLE, FEED, DRAIN, WAIT_LO, WAIT_HI and DONE.
REQ-012 IDLE: on start with n_sym != 0 and a valid rate, latch ncbps, clear sym_count and the bit counter, and go to FEED; start with n_sym == 0 SHALL pulse done only.
REQ-013 FEED: bit_ready=1 and deint_enable=1; each accepted bit (bit_valid and bit_ready) SHALL appear on deint_data/deint_valid exactly one cycle later and SHALL increment the 9-bit counter.
REQ-014 When the ncbps-th bit is accepted, bit_ready SHALL deassert in the following cycle and the FSM SHALL enter DRAIN; exactly ncbps bits SHALL be forwarded per symbol.
REQ-015 DRAIN: deint_valid=0 and deint_enable=1 for one cycle, then go to WAIT_LO.
REQ-016 WAIT_LO: wait for deint_finished==0; then go to WAIT_HI.
REQ-017 WAIT_HI: wait for deint_finished==1; then increment sym_count and return to FEED, or go to DONE when sym_count+1 == n_sym.
REQ-018 Watchdog: a cycle counter SHALL run in WAIT_LO and WAIT_HI; on reaching WDOG_MAX it SHALL set err[1], deassert deint_enable, and go to DONE.
REQ-019 DONE: pulse done for one cycle and return to IDLE; busy=1 in every state except IDLE.
REQ-020 A bit_valid pulse while bit_ready==0 and busy==1 SHALL set err[0]; that bit SHALL be dropped.
REQ-021 start while busy SHALL be ignored.
REQ-022 err SHALL clear only on reset or on an accepted start.
REQ-023 The bit counter SHALL be 9 bits and SHALL never wrap within a symbol; sym_count SHALL saturate at n_sym.

Reset
REQ-030 On reset, all outputs SHALL be 0 (including bit_ready, deint_enable, done, err, ncbps and sym_count), the FSM SHALL be in IDLE, and all counters SHALL be cleared.
REQ-031 A reset asserted mid-frame SHALL take effect on the next edge with no further deint_valid.

Structure
REQ-040 The RATE codes, the NCBPS constants (48/96/192/288) and the state encoding SHALL reside in a shared wifi PHY package.
REQ-041 One sub-module, wifi_rate_decode (a registered rate-to-ncbps lookup with a valid flag), SHALL be used.

Verification
REQ-050 Rate 1101, n_sym=2, continuous bits -> 48 deint_valid pulses per symbol, two finished handshakes, done, sym_count=2.
REQ-051 Rate 0001, n_sym=1, bit_valid toggling 50% -> exactly 288 bits forwarded, each one cycle after acceptance.
REQ-052 Rate 0000 -> err=01, done on the next cycle, no deint_valid.
REQ-053 deint_finished held at 1 after DRAIN -> err[1] set after 1023 cycles, done pulsed, deint_enable=0.
REQ-054 bit_valid during WAIT_HI -> err[0] set, bit not forwarded, symbol count unaffected.
REQ-055 Reset at the 100th bit of a 192-bit symbol -> all outputs 0 next cycle; a new start runs normally.

Source files
------------

// File: rtl/wifi_deinterleaver_sched_pkg.sv
// ---------------------------------------------------------------------------
// wifi_deinterleaver_sched_pkg
// Shared 802.11a PHY definitions for the deinterleaver scheduler:
//   - RATE codes as transmitted in the SIGNAL field
//   - coded-bits-per-symbol (NCBPS) constants for each modulation
//   - scheduler FSM state encoding
//   - rate_to_ncbps(): RATE code -> NCBPS, 0 for an unsupported code
// ---------------------------------------------------------------------------
package wifi_deinterleaver_sched_pkg;

    // RATE codes (R1..R4 as a 4-bit vector, R1 in the MSB)
    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    // Coded bits per OFDM symbol
    localparam logic [8:0] NCBPS_BPSK  = 9'd48;
    localparam logic [8:0] NCBPS_QPSK  = 9'd96;
    localparam logic [8:0] NCBPS_16QAM = 9'd192;
    localparam logic [8:0] NCBPS_64QAM = 9'd288;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FEED    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_t;

    // Zero doubles as the "unsupported rate" marker since no valid NCBPS is 0.
    function automatic logic [8:0] rate_to_ncbps(input logic [3:0] rate);
        logic [8:0] n;
        case (rate)
            RATE_6M,  RATE_9M:  n = NCBPS_BPSK;
            RATE_12M, RATE_18M: n = NCBPS_QPSK;
            RATE_24M, RATE_36M: n = NCBPS_16QAM;
            RATE_48M, RATE_54M: n = NCBPS_64QAM;
            default:            n = 9'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wifi_rate_decode.sv
// ---------------------------------------------------------------------------
// wifi_rate_decode
// Registered RATE -> NCBPS lookup with a valid flag.
//   clk      in   clock
//   reset    in   synchronous active-high reset (clears ncbps_o/valid_o)
//   load_i   in   capture the decode of rate_i on this edge
//   rate_i   in   802.11a RATE code
//   hit_o    out  combinational: rate_i is a supported code
//   ncbps_o  out  registered NCBPS of the last loaded rate
//   valid_o  out  registered: last loaded rate was supported
// ---------------------------------------------------------------------------
module wifi_rate_decode
    import wifi_deinterleaver_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] rate_i,
    output logic       hit_o,
    output logic [8:0] ncbps_o,
    output logic       valid_o
);

    logic [8:0] lut_ncbps;
    logic [8:0] ncbps_q;
    logic       valid_q;

    assign lut_ncbps = rate_to_ncbps(rate_i);
    assign hit_o     = (lut_ncbps != 9'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ncbps_q <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            ncbps_q <= lut_ncbps;
            valid_q <= hit_o;
        end
    end

    assign ncbps_o = ncbps_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/wifi_deinterleaver_sched.sv
// ---------------------------------------------------------------------------
// wifi_deinterleaver_sched
// Feeds exactly NCBPS coded bits per OFDM symbol from the demapper into the
// deinterleaver, then waits for the deinterleaver's finished handshake
// (falling then rising edge of deint_finished) before the next symbol.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, rate, n_sym  frame start pulse, RATE code, symbol count
//   bit_in/bit_valid    demapper bit stream; bit_ready = scheduler accepts
//   deint_finished      deinterleaver idle flag
//   deint_enable        deinterleaver enable
//   deint_data/_valid   bit to the deinterleaver, one cycle after acceptance
//   ncbps, sym_count    coded bits per symbol, symbols completed
//   busy, done          frame in progress, one-cycle end-of-frame pulse
//   err                 sticky: bit0 overflow/bad rate, bit1 watchdog
// ---------------------------------------------------------------------------
module wifi_deinterleaver_sched
    import wifi_deinterleaver_sched_pkg::*;
#(
    parameter int NSYM_W   = 12,
    parameter int WDOG_MAX = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        rate,
    input  logic [NSYM_W-1:0] n_sym,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic              deint_finished,
    output logic              deint_enable,
    output logic              deint_data,
    output logic              deint_valid,
    output logic [8:0]        ncbps,
    output logic [NSYM_W-1:0] sym_count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int WDOG_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

    sched_state_t      state_q, state_d;
    logic [8:0]        bit_cnt_q, bit_cnt_d;
    logic [NSYM_W-1:0] sym_count_q, sym_count_d;
    logic [NSYM_W-1:0] n_sym_q, n_sym_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [1:0]        err_q, err_d;
    logic              done_q, done_d;
    logic              deint_data_q;
    logic              deint_valid_q;

    logic              dec_load;
    logic              dec_hit;
    logic              dec_valid;
    logic [8:0]        dec_ncbps;
    logic              accept;

    wifi_rate_decode u_rate_decode (
        .clk     (clk),
        .reset   (reset),
        .load_i  (dec_load),
        .rate_i  (rate),
        .hit_o   (dec_hit),
        .ncbps_o (dec_ncbps),
        .valid_o (dec_valid)
    );

    assign busy         = (state_q != ST_IDLE);
    assign bit_ready    = (state_q == ST_FEED) && dec_valid;
    assign deint_enable = (state_q inside {ST_FEED, ST_DRAIN, ST_WAIT_LO, ST_WAIT_HI});
    assign accept       = bit_valid && bit_ready;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sym_count_d = sym_count_q;
        n_sym_d     = n_sym_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        done_d      = 1'b0;
        dec_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!dec_hit) begin
                        err_d  = 2'b01;
                        done_d = 1'b1;
                    end else if (n_sym == '0) begin
                        err_d  = 2'b00;
                        done_d = 1'b1;
                    end else begin
                        err_d       = 2'b00;
                        dec_load    = 1'b1;
                        n_sym_d     = n_sym;
                        sym_count_d = '0;
                        bit_cnt_d   = '0;
                        state_d     = ST_FEED;
                    end
                end
            end

            ST_FEED: begin
                if (accept) begin
                    bit_cnt_d = bit_cnt_q + 9'd1;
                    if (bit_cnt_q + 9'd1 == dec_ncbps) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            // No new bits are taken here; the pipeline register still carries
            // the final accepted bit of the symbol out during this cycle.
            ST_DRAIN: begin
                wdog_d  = '0;
                state_d = ST_WAIT_LO;
            end

            // A real handshake edge wins over a coincident watchdog expiry.
            ST_WAIT_LO: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (!deint_finished) begin
                    state_d = ST_WAIT_HI;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d[1] = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            ST_WAIT_HI: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (deint_finished) begin
                    if (sym_count_q != n_sym_q) begin
                        sym_count_d = sym_count_q + NSYM_W'(1);
                    end
                    if (sym_count_q + NSYM_W'(1) == n_sym_q) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = ST_FEED;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    err_d[1] = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A bit offered while the scheduler is not taking bits is dropped.
        if (bit_valid && !bit_ready && busy) begin
            err_d[0] = 1'b1;
        end

        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            sym_count_q   <= '0;
            n_sym_q       <= '0;
            wdog_q        <= '0;
            err_q         <= '0;
            done_q        <= 1'b0;
            deint_data_q  <= 1'b0;
            deint_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sym_count_q   <= sym_count_d;
            n_sym_q       <= n_sym_d;
            wdog_q        <= wdog_d;
            err_q         <= err_d;
            done_q        <= done_d;
            deint_valid_q <= accept;
            if (accept) begin
                deint_data_q <= bit_in;
            end
        end
    end

    assign deint_data  = deint_data_q;
    assign deint_valid = deint_valid_q;
    assign ncbps       = dec_ncbps;
    assign sym_count   = sym_count_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_wifi_deinterleaver_sched.sv
// ---------------------------------------------------------------------------
// tb_wifi_deinterleaver_sched
// Scoreboard bench: every bit accepted by the scheduler is pushed with the
// cycle in which it must appear on deint_data/deint_valid; a negedge monitor
// pops and compares. Frame-level outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_wifi_deinterleaver_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  rate;
    logic [11:0] n_sym;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic        deint_finished;
    logic        deint_enable;
    logic        deint_data;
    logic        deint_valid;
    logic [8:0]  ncbps;
    logic [11:0] sym_count;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    typedef struct {
        int unsigned cyc;
        logic        b;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_fwd = 0;

    wifi_deinterleaver_sched #(
        .NSYM_W   (12),
        .WDOG_MAX (1023)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .rate           (rate),
        .n_sym          (n_sym),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .deint_finished (deint_finished),
        .deint_enable   (deint_enable),
        .deint_data     (deint_data),
        .deint_valid    (deint_valid),
        .ncbps          (ncbps),
        .sym_count      (sym_count),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: each forwarded bit must match the oldest accepted bit
    // and arrive exactly in the cycle following its acceptance.
    always @(negedge clk) begin
        exp_t e;
        if (deint_valid === 1'b1) begin
            n_fwd++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("bit_data", {31'd0, deint_data}, {31'd0, e.b});
                check_val("bit_latency", cyc, e.cyc);
            end
        end
        cyc++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {bit_ready, deint_enable, deint_data, deint_valid, ncbps,
                        sym_count, busy, done, err}, 32'd0);
    endtask

    task automatic start_frame(input logic [3:0] r, input logic [11:0] ns);
        start = 1'b1;
        rate  = r;
        n_sym = ns;
        tick();
        start = 1'b0;
    endtask

    // Offer bits until bit_ready drops; mode 0 = continuous, 1 = every other cycle.
    task automatic feed_symbol(input int mode, input int exp_n);
        exp_t e;
        int   acc   = 0;
        int   guard = 0;
        while (bit_ready === 1'b1 && guard < 4000) begin
            bit_valid = (mode == 0) ? 1'b1 : ((guard % 2) == 0);
            bit_in    = 1'($urandom_range(0, 1));
            if (bit_valid) begin
                e.cyc = cyc;
                e.b   = bit_in;
                sb_q.push_back(e);
                acc++;
            end
            tick();
            guard++;
        end
        bit_valid = 1'b0;
        check_val("feed_bound", {31'd0, guard < 4000}, 32'd1);
        check_val("bits_per_symbol", acc, exp_n);
    endtask

    task automatic run_frame(input logic [3:0] r, input logic [11:0] ns,
                             input int exp_n, input int mode, input bit inj);
        $display("frame rate=%b n_sym=%0d ncbps=%0d mode=%0d inject=%0d", r, ns, exp_n, mode, inj);
        n_fwd = 0;
        start_frame(r, ns);
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        check_val("ncbps", {23'd0, ncbps}, exp_n);
        check_val("err_cleared", {30'd0, err}, 32'd0);
        for (int s = 0; s < int'(ns); s++) begin
            feed_symbol(mode, exp_n);
            check_val("drain_enable", {31'd0, deint_enable}, 32'd1);
            deint_finished = 1'b0;
            tick();
            tick();
            if (inj && s == 0) begin
                check_val("ready_in_wait", {31'd0, bit_ready}, 32'd0);
                bit_valid = 1'b1;
                bit_in    = 1'b1;
                tick();
                bit_valid = 1'b0;
                check_val("overflow_err", {30'd0, err}, 32'd1);
                check_val("sym_unaffected", {20'd0, sym_count}, s);
            end else begin
                tick();
            end
            deint_finished = 1'b1;
            tick();
            if (s < int'(ns) - 1) begin
                check_val("sym_count", {20'd0, sym_count}, s + 1);
                check_val("ready_next_sym", {31'd0, bit_ready}, 32'd1);
            end else begin
                check_val("done_pulse", {31'd0, done}, 32'd1);
                check_val("sym_final", {20'd0, sym_count}, {20'd0, ns});
                tick();
                check_val("done_clear", {31'd0, done}, 32'd0);
                check_val("idle_busy", {31'd0, busy}, 32'd0);
            end
        end
        check_val("fwd_total", n_fwd, exp_n * int'(ns));
        check_val("sb_empty", sb_q.size(), 32'd0);
        check_val("err_end", {30'd0, err}, inj ? 32'd1 : 32'd0);
    endtask

    initial begin
        int cnt;
        exp_t e;
        reset          = 1'b1;
        start          = 1'b0;
        rate           = 4'd0;
        n_sym          = 12'd0;
        bit_in         = 1'b0;
        bit_valid      = 1'b0;
        deint_finished = 1'b1;
        tick();
        tick();
        tick();
        check_all_zero("reset_outputs");
        reset = 1'b0;
        tick();

        // Unsupported rate: err[0] and done next cycle, nothing forwarded.
        $display("frame rate=0000 n_sym=3 (unsupported)");
        start_frame(4'b0000, 12'd3);
        check_val("bad_rate_err", {30'd0, err}, 32'd1);
        check_val("bad_rate_done", {31'd0, done}, 32'd1);
        check_val("bad_rate_busy", {31'd0, busy}, 32'd0);
        check_val("bad_rate_enable", {31'd0, deint_enable}, 32'd0);
        tick();
        check_val("bad_rate_done_clr", {31'd0, done}, 32'd0);

        // n_sym == 0: done pulse only.
        $display("frame rate=1101 n_sym=0");
        start_frame(4'b1101, 12'd0);
        check_val("nsym0_done", {31'd0, done}, 32'd1);
        check_val("nsym0_busy", {31'd0, busy}, 32'd0);
        tick();

        run_frame(4'b1101, 12'd2, 48, 0, 1'b0);
        run_frame(4'b0001, 12'd1, 288, 1, 1'b0);
        run_frame(4'b0111, 12'd1, 96, 0, 1'b0);
        run_frame(4'b1011, 12'd1, 192, 1, 1'b0);
        run_frame(4'b1101, 12'd2, 48, 0, 1'b1);

        // Watchdog: deint_finished never falls after the symbol.
        $display("frame rate=1111 n_sym=1 watchdog");
        n_fwd = 0;
        start_frame(4'b1111, 12'd1);
        feed_symbol(0, 48);
        cnt = 0;
        while (done !== 1'b1 && cnt < 1200) begin
            tick();
            cnt++;
        end
        // One edge from DRAIN into the wait plus 1023 waiting cycles.
        check_val("wdog_cycles", cnt, 32'd1024);
        check_val("wdog_err", {30'd0, err}, 32'd2);
        check_val("wdog_enable", {31'd0, deint_enable}, 32'd0);
        tick();
        check_val("wdog_idle", {31'd0, busy}, 32'd0);
        check_val("wdog_fwd", n_fwd, 32'd48);

        // Reset at the 100th bit of a 192-bit symbol.
        $display("frame rate=1001 n_sym=1 reset at bit 100");
        start_frame(4'b1001, 12'd1);
        for (int i = 0; i < 99; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(0, 1));
            e.cyc     = cyc;
            e.b       = bit_in;
            sb_q.push_back(e);
            tick();
        end
        reset     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        check_all_zero("midframe_reset");
        bit_valid = 1'b0;
        reset     = 1'b0;
        tick();
        check_all_zero("after_reset");
        check_val("reset_sb_empty", sb_q.size(), 32'd0);
        run_frame(4'b1101, 12'd1, 48, 0, 1'b0);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
